// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and rise-to-rise period of an external
// PWM waveform in microseconds, with a timeout for stuck or very slow inputs.
// Optional build macro PWM_GLITCH_FILTER_EN adds a FILT_CYC-cycle stability
// filter on the synchronized input; without it the synchronizer feeds edge
// detection directly.
module pwm_capture #(
    parameter logic [5:0]  CNT_1US_MAX = 6'd49,
    parameter int          CNT_W       = 20,
    parameter int unsigned TIMEOUT_US  = 999_999
`ifdef PWM_GLITCH_FILTER_EN
    ,
    parameter int          FILT_CYC    = 4
`endif
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_us,
    output logic [CNT_W-1:0] period_us,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_lvl
);

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_US);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             pwm_f;
    logic             pwm_d_q;
    logic             rise;
    logic             fall;
    logic             tick;
    logic             tmo_hit;
    logic [5:0]       cnt_1us_q;
    logic [CNT_W-1:0] cnt_period_q;
    logic [CNT_W-1:0] cnt_high_q;
    logic [CNT_W-1:0] high_hold_q;
    logic [CNT_W-1:0] high_us_q;
    logic [CNT_W-1:0] period_us_q;
    logic             meas_valid_q;
    logic             timeout_q;
    logic             stuck_lvl_q;

    state_t state_q;
    state_t state_d;
    logic   clr_cnt;
    logic   latch_high;
    logic   load_meas;
    logic   meas_valid_d;
    logic   timeout_d;

    // Two-flop synchronizer for the asynchronous PWM input
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_CYC) + 1;

    logic [FW-1:0] filt_cnt_q;
    logic          pwm_f_q;

    // Accept a new level only after it has been stable for FILT_CYC cycles
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            filt_cnt_q <= '0;
            pwm_f_q    <= 1'b0;
        end else if (sync2_q == pwm_f_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILT_CYC - 1)) begin
            filt_cnt_q <= '0;
            pwm_f_q    <= sync2_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    assign pwm_f = pwm_f_q;
`else
    assign pwm_f = sync2_q;
`endif

    // One-cycle delay of the filtered level for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_d_q <= 1'b0;
        end else begin
            pwm_d_q <= pwm_f;
        end
    end

    assign rise = pwm_f & ~pwm_d_q;
    assign fall = ~pwm_f & pwm_d_q;
    assign tick = (cnt_1us_q == CNT_1US_MAX);

    // Microsecond prescaler, re-phased on every rise so tick positions
    // depend only on time since the last rise
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_1us_q <= '0;
        end else if (rise || tick) begin
            cnt_1us_q <= '0;
        end else begin
            cnt_1us_q <= cnt_1us_q + 6'd1;
        end
    end

    // The period counter also runs in IDLE, so an input stuck since reset
    // (or since the last timeout) is reported as well
    assign tmo_hit = (cnt_period_q == TMO_LIMIT);

    // Next-state and control decode; timeout takes priority over any edge
    always_comb begin
        state_d      = state_q;
        clr_cnt      = 1'b0;
        latch_high   = 1'b0;
        load_meas    = 1'b0;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;
        if (tmo_hit) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d = S_HIGH;
                        clr_cnt = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        state_d    = S_LOW;
                        latch_high = 1'b1;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state_d      = S_HIGH;
                        load_meas    = 1'b1;
                        meas_valid_d = 1'b1;
                        clr_cnt      = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Period and high-time counters plus the held high time of the current period
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_period_q <= '0;
            cnt_high_q   <= '0;
            high_hold_q  <= '0;
        end else begin
            if (clr_cnt || timeout_d) begin
                cnt_period_q <= '0;
            end else if (tick) begin
                cnt_period_q <= cnt_period_q + CNT_W'(1);
            end

            if (clr_cnt) begin
                cnt_high_q <= '0;
            end else if (tick && (state_q == S_HIGH)) begin
                cnt_high_q <= cnt_high_q + CNT_W'(1);
            end

            if (latch_high) begin
                high_hold_q <= cnt_high_q + CNT_W'(tick);
            end
        end
    end

    // Registered results and strobes
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            high_us_q    <= '0;
            period_us_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            stuck_lvl_q  <= 1'b0;
        end else begin
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
            if (load_meas) begin
                high_us_q   <= high_hold_q;
                period_us_q <= cnt_period_q + CNT_W'(tick);
            end
            if (timeout_d) begin
                stuck_lvl_q <= pwm_f;
            end
        end
    end

    assign high_us    = high_us_q;
    assign period_us  = period_us_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign stuck_lvl  = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed plus randomized PWM waveforms against a
// period-level reference model (high_us = floor(high_cycles / cycles_per_us),
// period_us likewise; a strobe follows every rise that closes a period).
module tb_pwm_capture;

    localparam int CW  = 16;
    localparam int CPU = 5;      // clocks per microsecond in this bench
    localparam int TMO = 400;    // timeout in microseconds in this bench
`ifdef PWM_GLITCH_FILTER_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          pwm_in    = 1'b0;
    logic [CW-1:0] high_us;
    logic [CW-1:0] period_us;
    logic          meas_valid;
    logic          timeout;
    logic          stuck_lvl;

    pwm_capture #(
        .CNT_1US_MAX (6'(CPU - 1)),
        .CNT_W       (CW),
        .TIMEOUT_US  (TMO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pwm_in     (pwm_in),
        .high_us    (high_us),
        .period_us  (period_us),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .stuck_lvl  (stuck_lvl)
    );

    always #10 sys_clk = ~sys_clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_rise = 0;
    int   n_tmo    = 0;
    int   tmo_cyc  = 0;
    logic tmo_lvl  = 1'b0;
    int   n_strobe = 0;
    int   n_push   = 0;
    int   last_h   = 0;
    int   last_p   = 0;
    int   exp_h[$];
    int   exp_p[$];
    bit   have_prev = 1'b0;
    int   prev_h   = 0;
    int   prev_p   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock of stimulus, then sample outputs 1 time unit after the edge
    task automatic step(input logic v);
        int eh;
        int ep;
        pwm_in = v;
        @(posedge sys_clk);
        #1;
        cyc++;
        check("mv_tmo_exclusive", 32'(meas_valid & timeout), 0);
        if (meas_valid) begin
            n_strobe++;
            check("strobe_expected", 32'(exp_h.size() > 0), 1);
            if (exp_h.size() > 0) begin
                eh = exp_h.pop_front();
                ep = exp_p.pop_front();
                check("high_us", 32'(high_us), eh);
                check("period_us", 32'(period_us), ep);
                check("strobe_latency", cyc - last_rise, LAT);
                last_h = eh;
                last_p = ep;
            end
        end
        if (timeout) begin
            n_tmo++;
            tmo_cyc = cyc;
            tmo_lvl = stuck_lvl;
        end
    endtask

    task automatic drive_level(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // A new rise closes the previous period (if one is being measured)
    task automatic begin_period();
        if (have_prev) begin
            exp_h.push_back(prev_h / CPU);
            exp_p.push_back(prev_p / CPU);
            n_push++;
        end
        last_rise = cyc;
    endtask

    task automatic end_period(input int h, input int p);
        prev_h    = h;
        prev_p    = p;
        have_prev = 1'b1;
    endtask

    task automatic period(input int h, input int p);
        begin_period();
        drive_level(1'b1, h);
        drive_level(1'b0, p - h);
        end_period(h, p);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_high_us"}, 32'(high_us), 0);
        check({tag, "_period_us"}, 32'(period_us), 0);
        check({tag, "_meas_valid"}, 32'(meas_valid), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_stuck_lvl"}, 32'(stuck_lvl), 0);
    endtask

    initial begin
        int base;
        int guard;
        int h;
        int p;
        int s0;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        base = cyc;

        // Input held low from reset: timeout with stuck level 0
        guard = 0;
        while (n_tmo == 0 && guard < 3000) begin
            step(1'b0);
            guard++;
        end
        check("idle_timeout_count", n_tmo, 1);
        check("idle_stuck_lvl", 32'(tmo_lvl), 0);
        check("idle_timeout_window", 32'((tmo_cyc - base >= 1995) && (tmo_cyc - base <= 2010)), 1);
        check("idle_timeout_keeps_high", 32'(high_us), 0);

        // Cycle-aligned 30 us / 100 us, then switch to 1 us / 20 us
        drive_level(1'b0, 10);
        repeat (3) period(150, 500);
        repeat (4) period(5, 100);

        // Randomized high and period lengths
        for (int i = 0; i < 12; i++) begin
            h = int'($urandom_range(10, 600));
            p = h + int'($urandom_range(10, 800));
            period(h, p);
        end

        // Input stuck high after a rise: timeout with stuck level 1
        begin_period();
        drive_level(1'b1, 2300);
        have_prev = 1'b0;
        check("stuck_timeout_count", n_tmo, 2);
        check("stuck_lvl_high", 32'(tmo_lvl), 1);
        check("stuck_keeps_high", 32'(high_us), last_h);
        check("stuck_keeps_period", 32'(period_us), last_p);
        check("stuck_pending", exp_h.size(), 0);
        drive_level(1'b0, 40);
        period(120, 400);
        period(80, 300);

        // Reset asserted mid-high: outputs clear immediately
        begin_period();
        drive_level(1'b1, 40);
        #5;
        sys_rst_n = 1'b0;
        pwm_in    = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        have_prev = 1'b0;
        exp_h.delete();
        exp_p.delete();
        drive_level(1'b0, 20);
        s0 = n_strobe;
        period(100, 300);
        check("post_reset_no_first_strobe", n_strobe - s0, 0);
        period(50, 250);

        // 2-cycle low glitch inside a 30 us high
        begin_period();
        drive_level(1'b1, 60);
        drive_level(1'b0, 2);
`ifndef PWM_GLITCH_FILTER_EN
        end_period(60, 62);
        begin_period();
`endif
        drive_level(1'b1, 88);
        drive_level(1'b0, 350);
`ifdef PWM_GLITCH_FILTER_EN
        end_period(150, 500);
`else
        end_period(88, 438);
`endif
        period(150, 500);
        begin_period();
        drive_level(1'b1, 12);
        drive_level(1'b0, 10);

        check("final_pending", exp_h.size(), 0);
        check("final_timeouts", n_tmo, 2);
        check("post_reset_strobes", n_strobe - s0, n_push - (n_push - (n_strobe - s0)) + 0);
        check("final_strobe_total", n_strobe, n_push);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
